sysid_timestamp_regs: RTL and testbench

- Parametrised successor to the Qsys system-ID slave: an Avalon-MM read slave that returns a system ID and a build timestamp.
- Adds a free-running uptime counter, a host-writable scratch register, and a snapshot mechanism so the 64-bit uptime reads coherently over a 32-bit bus.
- Has one wait-state read pipeline. Sits on the Nios II data master, next to the other control-slave peripherals.

---
 rtl/sysid_timestamp_regs.sv | 156 +++++++++++++++
 tb/tb_sysid_timestamp_regs.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sysid_timestamp_regs.sv
// ---------------------------------------------------------------------------
// sysid_timestamp_regs
//
// Avalon-MM control slave returning a system ID and a build timestamp, plus a
// free-running uptime counter, a host-writable scratch register and a
// capability word. Reads take one wait state: the register value is sampled
// on the strobe cycle and presented with readdatavalid two cycles after it.
//
// A read of the uptime low word (word 2) also latches the upper uptime bits
// into a snapshot register (word 3). This makes {word3, word2} one coherent
// uptime value even if the low word wraps between the two bus reads.
//
// Ports
//   clock          in   system clock
//   reset_n        in   asynchronous active-low reset
//   address        in   word address (ADDR_W)
//   read           in   read strobe, held by the master while waitrequest=1
//   write          in   write strobe (zero wait-state)
//   writedata      in   write data (DATA_W)
//   readdata       out  registered read data (DATA_W)
//   readdatavalid  out  one-cycle pulse qualifying readdata
//   waitrequest    out  high while a read is in flight
//   uptime_tick    out  one-cycle pulse when the low 32 uptime bits wrap
//
// Register map (word address)
//   0 ID_VALUE  1 TIMESTAMP  2 uptime[31:0]  3 snapshot (uptime high bits)
//   4 scratch (RW)  5 {UPTIME_W[7:0], DATA_W[7:0], 16'h0001}  6,7 zero
// ---------------------------------------------------------------------------
module sysid_timestamp_regs #(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h5664_D69D,
    parameter int          DATA_W    = 32,   // 16 or 32
    parameter int          UPTIME_W  = 48,   // 33..64
    parameter int          ADDR_W    = 3     // must be 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    output logic              uptime_tick
);

    localparam int HI_W = UPTIME_W - 32;
    localparam logic [UPTIME_W-1:0] UPTIME_ONE = 1;
    localparam logic [31:0] CAP_WORD = {8'(UPTIME_W), 8'(DATA_W), 16'h0001};

    typedef enum logic {IDLE, BUSY} state_e;

    state_e              state_q, state_d;
    logic [UPTIME_W-1:0] uptime_q, uptime_d;
    logic [HI_W-1:0]     snap_q, snap_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic [31:0]         src_q, src_d;        // value sampled at the strobe
    logic [DATA_W-1:0]   readdata_q, readdata_d;
    logic                rdv_q, rdv_d;
    logic                wait_q, wait_d;
    logic                tick_q, tick_d;
    logic [31:0]         reg_word;
    logic                rd_accept;
    logic                wr_accept;

    // A read wins over a simultaneous write; nothing is accepted while BUSY.
    assign rd_accept = (state_q == IDLE) && read;
    assign wr_accept = (state_q == IDLE) && write && !read && (address == ADDR_W'(4));

    // Register read mux, zero-extended to 32 bits and truncated on output.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        reg_word = 32'h0;
        case (address)
            ADDR_W'(0): reg_word = ID_VALUE;
            ADDR_W'(1): reg_word = TIMESTAMP;
            ADDR_W'(2): reg_word = uptime_q[31:0];
            ADDR_W'(3): reg_word = 32'(snap_q);
            ADDR_W'(4): reg_word = 32'(scratch_q);
            ADDR_W'(5): reg_word = CAP_WORD;
            default:    reg_word = 32'h0;
        endcase
    end

    // Datapath next-state: counter, wrap tick, snapshot, scratch.
    always_comb begin
        uptime_d  = uptime_q + UPTIME_ONE;
        tick_d    = (uptime_q[31:0] == 32'hFFFF_FFFF);
        snap_d    = (rd_accept && address == ADDR_W'(2)) ? uptime_q[UPTIME_W-1:32] : snap_q;
        scratch_d = wr_accept ? writedata : scratch_q;
    end

    // Read FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (read) state_d = BUSY;
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM: output logic (feeds the registered bus outputs).
    always_comb begin
        src_d      = src_q;
        readdata_d = readdata_q;
        rdv_d      = 1'b0;
        wait_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    src_d  = reg_word;
                    wait_d = 1'b1;
                end
            end
            BUSY: begin
                readdata_d = src_q[DATA_W-1:0];
                rdv_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Read FSM state register and all other state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= IDLE;
            uptime_q   <= '0;
            snap_q     <= '0;
            scratch_q  <= '0;
            src_q      <= '0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
            wait_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            uptime_q   <= uptime_d;
            snap_q     <= snap_d;
            scratch_q  <= scratch_d;
            src_q      <= src_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
            wait_q     <= wait_d;
            tick_q     <= tick_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;
    assign waitrequest   = wait_q;
    assign uptime_tick   = tick_q;

endmodule

// File: tb/tb_sysid_timestamp_regs.sv
// ---------------------------------------------------------------------------
// tb_sysid_timestamp_regs
//
// Directed bench for sysid_timestamp_regs. Two instances share the bus
// inputs: the default build (DATA_W=32, UPTIME_W=48) and a narrow build
// (DATA_W=16, UPTIME_W=40). Inputs change just after the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sysid_timestamp_regs;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;

    logic [31:0] rd32;
    logic        rdv32, wait32, tick32;
    logic [15:0] rd16;
    logic        rdv16, wait16, tick16;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    logic use16 = 1'b0;

    logic [31:0] obs_rd;
    logic        obs_rdv, obs_wait;

    always #5 clock = ~clock;

    sysid_timestamp_regs dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(rd32),
        .readdatavalid(rdv32), .waitrequest(wait32), .uptime_tick(tick32)
    );

    sysid_timestamp_regs #(.DATA_W(16), .UPTIME_W(40)) dut16 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata[15:0]), .readdata(rd16),
        .readdatavalid(rdv16), .waitrequest(wait16), .uptime_tick(tick16)
    );

    always_comb begin
        obs_rd   = use16 ? {16'h0, rd16} : rd32;
        obs_rdv  = use16 ? rdv16 : rdv32;
        obs_wait = use16 ? wait16 : wait32;
    end

    // Count cycles in which the wide instance reports a low-word wrap.
    always @(negedge clock) if (tick32) tick_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Strobe is sampled on the next rising
    // edge; waitrequest is high for the following cycle and readdatavalid
    // arrives two cycles after the strobe. Returns just after a falling edge.
    task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        read    = 1'b1;
        address = a;
        @(negedge clock);
        write = 1'b0;
        check({tag, "/wait_busy"}, 32'(obs_wait), 32'd1);
        check({tag, "/rdv_early"}, 32'(obs_rdv), 32'd0);
        @(negedge clock);
        read = 1'b0;
        check({tag, "/rdv"}, 32'(obs_rdv), 32'd1);
        check({tag, "/data"}, obs_rd, exp);
        check({tag, "/wait_done"}, 32'(obs_wait), 32'd0);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        write     = 1'b1;
        address   = a;
        writedata = d;
        @(negedge clock);
        write = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 3'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'h0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst/readdata", rd32, 32'h0);
        check("rst/rdv", 32'(rdv32), 32'd0);
        check("rst/wait", 32'(wait32), 32'd0);
        check("rst/tick", 32'(tick32), 32'd0);
        reset_n = 1'b1;

        // Counter has advanced by exactly five clocks since reset release.
        repeat (5) @(negedge clock);
        do_read(3'd2, 32'd5, "uptime_after_rst");

        // Read-only identification words and unused addresses.
        do_read(3'd0, 32'h0000_0000, "id");
        do_read(3'd1, 32'h5664_D69D, "timestamp");
        do_read(3'd5, 32'h3020_0001, "capability");
        do_read(3'd6, 32'h0, "addr6");
        do_read(3'd7, 32'h0, "addr7");

        // Scratch is writable; other addresses ignore writes.
        do_write(3'd4, 32'hA5A5_1234);
        do_read(3'd4, 32'hA5A5_1234, "scratch_wr");
        do_write(3'd1, 32'h0000_0001);
        do_read(3'd1, 32'h5664_D69D, "timestamp_ro");
        do_write(3'd6, 32'hFFFF_FFFF);
        do_read(3'd6, 32'h0, "addr6_ro");

        // Read and write together: read returns old scratch, write dropped.
        write     = 1'b1;
        writedata = 32'h0000_DEAD;
        do_read(3'd4, 32'hA5A5_1234, "rw_collide");
        do_read(3'd4, 32'hA5A5_1234, "rw_scratch_kept");

        // Write presented during BUSY is held off.
        read    = 1'b1;
        address = 3'd0;
        @(negedge clock);
        read      = 1'b0;
        write     = 1'b1;
        address   = 3'd4;
        writedata = 32'h0000_0077;
        @(negedge clock);
        write = 1'b0;
        check("busy_wr/rdv", 32'(rdv32), 32'd1);
        check("busy_wr/data", rd32, 32'h0);
        do_read(3'd4, 32'hA5A5_1234, "busy_wr_ignored");

        // Snapshot coherency across a low-word wrap.
        check("tick_before_wrap", 32'(tick_cnt), 32'd0);
        force dut.uptime_q = 48'h0000_FFFF_FFFE;
        #1;
        release dut.uptime_q;
        do_read(3'd2, 32'hFFFF_FFFE, "snap_lo");
        do_read(3'd3, 32'h0000_0000, "snap_hi");
        check("tick_once", 32'(tick_cnt), 32'd1);

        // Reset during the BUSY cycle aborts the read.
        read    = 1'b1;
        address = 3'd1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        read = 1'b0;
        check("midrst/wait", 32'(wait32), 32'd0);
        check("midrst/rdv", 32'(rdv32), 32'd0);
        check("midrst/readdata", rd32, 32'h0);
        check("midrst/tick", 32'(tick32), 32'd0);
        @(negedge clock);
        check("midrst/rdv_held", 32'(rdv32), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        do_read(3'd2, 32'd3, "midrst_uptime");
        do_read(3'd4, 32'h0, "midrst_scratch");
        check("midrst_no_tick", 32'(tick_cnt), 32'd1);

        // Narrow build: lower 16 bits only, same latency.
        use16 = 1'b1;
        do_read(3'd5, 32'h0000_0001, "w16_capability");
        do_read(3'd1, 32'h0000_D69D, "w16_timestamp");
        do_write(3'd4, 32'h1234_ABCD);
        do_read(3'd4, 32'h0000_ABCD, "w16_scratch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
